// File: rtl/mem_port_arbiter.sv
// Two-master (IFU/LSU), one-slave arbiter for the shared memory port.
// One outstanding transaction, round-robin on contention, watchdog -> error response.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp_err,

  output logic                busy,
  output logic                grant_lsu
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  state_t              state, state_nxt;
  logic                owner;       // 1 = LSU
  logic                last_grant;  // 1 = LSU
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;

  logic lsu_win, ifu_win, grant_fire;
  logic owner_resp_ready, resp_fire, expired;

  // Arbitration and handshake qualifiers
  always_comb begin
    lsu_win          = lsu_req_valid & (~ifu_req_valid | ~last_grant);
    ifu_win          = ifu_req_valid & ~lsu_win;
    grant_fire       = (state == IDLE) & (ifu_win | lsu_win);
    owner_resp_ready = owner ? lsu_resp_ready : ifu_resp_ready;
    resp_fire        = (state == RESP) & mem_resp_valid & owner_resp_ready;
    expired          = (TIMEOUT != 0) && (cnt == CNT_LAST);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; expiry in REQ goes to ERR even if the slave accepts
  // that same cycle, since only a response handshake completes a transaction.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (grant_fire) state_nxt = REQ;
      REQ: begin
        if (expired)            state_nxt = ERR;
        else if (mem_req_ready) state_nxt = RESP;
      end
      RESP: begin
        if (resp_fire)    state_nxt = IDLE;
        else if (expired) state_nxt = ERR;
      end
      ERR: if (owner_resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, ownership and watchdog counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= 1'b0;
      last_grant <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else if (grant_fire) begin
      owner      <= lsu_win;
      last_grant <= lsu_win;
      cnt        <= '0;
      addr_q     <= lsu_win ? lsu_addr  : ifu_addr;
      wen_q      <= lsu_win ? lsu_wen   : 1'b0;
      wdata_q    <= lsu_win ? lsu_wdata : '0;
      wmask_q    <= lsu_win ? lsu_wmask : '0;
    end else if ((state == REQ || state == RESP) && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Output decode; handshake outputs are forced low while reset is asserted
  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    ifu_resp_err   = 1'b0;
    lsu_resp_err   = 1'b0;
    mem_addr       = addr_q;
    mem_wen        = wen_q;
    mem_wdata      = wdata_q;
    mem_wmask      = wmask_q;
    busy           = (state != IDLE);
    grant_lsu      = (state != IDLE) & owner;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          ifu_req_ready = ifu_win;
          lsu_req_ready = lsu_win;
        end
        REQ: mem_req_valid = 1'b1;
        RESP: begin
          mem_resp_ready = owner_resp_ready;
          if (owner) begin
            lsu_resp_valid = mem_resp_valid;
            lsu_rdata      = mem_rdata;
            lsu_resp_err   = mem_resp_err;
          end else begin
            ifu_resp_valid = mem_resp_valid;
            ifu_rdata      = mem_rdata;
            ifu_resp_err   = mem_resp_err;
          end
        end
        ERR: begin
          if (owner) begin
            lsu_resp_valid = 1'b1;
            lsu_resp_err   = 1'b1;
          end else begin
            ifu_resp_valid = 1'b1;
            ifu_resp_err   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level reference model,
// randomized masters/slave, independent monitor on the handshakes.
module tb_mem_port_arbiter;

  localparam int T = 8;

  logic        clk, rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        busy, grant_lsu;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .busy(busy), .grant_lsu(grant_lsu)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct packed {
    logic        owner;  // 1 = LSU
    logic [31:0] data;
    logic        err;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    last_grant_m;   // model: 1 = LSU was granted last
  req_t  mon_rq;
  resp_t mon_rs;
  logic  mon_ifu_hs, mon_lsu_hs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  task automatic abort(input string why);
    checks++;
    errors++;
    $display("FAIL %s: transaction did not progress as modelled", why);
    summary();
    $fatal(1, "aborting run");
  endtask

  task automatic clear_inputs();
    ifu_req_valid  = 1'b0; lsu_req_valid  = 1'b0;
    ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    mem_req_ready  = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0; mem_rdata      = '0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"},        busy,           0);
    chk({tag, "_grant_lsu"},   grant_lsu,      0);
    chk({tag, "_ifu_rdy"},     ifu_req_ready,  0);
    chk({tag, "_lsu_rdy"},     lsu_req_ready,  0);
    chk({tag, "_mreq_valid"},  mem_req_valid,  0);
    chk({tag, "_mresp_rdy"},   mem_resp_ready, 0);
    chk({tag, "_ifu_rvalid"},  ifu_resp_valid, 0);
    chk({tag, "_lsu_rvalid"},  lsu_resp_valid, 0);
    chk({tag, "_mem_latch"},   {mem_addr, mem_wen, mem_wdata, mem_wmask}, 0);
  endtask

  // sel: 0 = IFU only, 1 = LSU only, 2 = both. d1 = slave request stall cycles,
  // d2 = extra cycles before the slave responds, rr = cycle (from grant) owner ready rises.
  task automatic run_txn(input int sel, input logic [31:0] iaddr, input logic [31:0] laddr,
                         input logic lwen, input logic [31:0] lwdata, input logic [3:0] lwmask,
                         input int d1, input int d2, input int rr,
                         input logic [31:0] sdata, input logic serr);
    bit    w, err, sv, mr, done;
    int    kc, ph;
    req_t  rq;
    resp_t rs;
    w  = (sel == 2) ? !last_grant_m : (sel == 1);
    last_grant_m = w;
    kc  = (d1 + 1 + d2 > rr) ? d1 + 1 + d2 : rr;
    err = (kc >= T);
    rq  = w ? '{laddr, lwen, lwdata, lwmask} : '{iaddr, 1'b0, 32'h0, 4'h0};
    if (d1 <= T - 1) req_q.push_back(rq);
    rs = '{w, err ? 32'h0 : sdata, err ? 1'b1 : serr};
    resp_q.push_back(rs);

    ifu_addr = iaddr; lsu_addr = laddr; lsu_wen = lwen; lsu_wdata = lwdata; lsu_wmask = lwmask;
    ifu_req_valid = (sel != 1);
    lsu_req_valid = (sel != 0);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("ifu_req_ready", ifu_req_ready, !w);
    chk("lsu_req_ready", lsu_req_ready, w);
    if (ifu_req_ready !== !w || lsu_req_ready !== w) abort("grant");
    @(posedge clk); #1;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    done = 1'b0;
    for (int k = 0; k < 48 && !done; k++) begin
      sv = (k >= d1 + 1 + d2) && (k < T);
      mr = (k >= rr);
      mem_req_ready  = (k == d1);
      mem_resp_valid = sv;
      mem_rdata      = sv ? sdata : $urandom;
      mem_resp_err   = sv ? serr : 1'($urandom_range(0, 1));
      if (w) begin
        lsu_resp_ready = mr; ifu_resp_ready = 1'($urandom_range(0, 1));
      end else begin
        ifu_resp_ready = mr; lsu_resp_ready = 1'($urandom_range(0, 1));
      end
      ifu_req_valid = 1'($urandom_range(0, 1));
      lsu_req_valid = 1'($urandom_range(0, 1));
      ifu_addr = $urandom; lsu_addr = $urandom;
      ph = (k >= T) ? 3 : (k <= d1) ? 1 : 2;
      @(negedge clk);
      chk("busy",           busy,           1);
      chk("grant_lsu",      grant_lsu,      w);
      chk("ifu_rdy_busy",   ifu_req_ready,  0);
      chk("lsu_rdy_busy",   lsu_req_ready,  0);
      chk("mem_req_valid",  mem_req_valid,  ph == 1);
      chk("mem_resp_ready", mem_resp_ready, ph == 2 && mr);
      chk("owner_rvalid",   w ? lsu_resp_valid : ifu_resp_valid, ph == 3 || (ph == 2 && sv));
      chk("other_rvalid",   w ? ifu_resp_valid : lsu_resp_valid, 0);
      chk("other_rdata",    w ? ifu_rdata : lsu_rdata, 0);
      if (ph == 1) chk("mem_addr_hold", mem_addr, rq.addr);
      done = (ph == 3 && mr) || (ph == 2 && sv && mr);
      @(posedge clk); #1;
    end
    if (!done) abort("txn_bound");
    clear_inputs();
  endtask

  task automatic mid_reset();
    req_t rq;
    lsu_addr = $urandom; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    rq = '{lsu_addr, 1'b0, 32'h0, 4'h0};
    req_q.push_back(rq);
    lsu_req_valid = 1'b1;
    @(negedge clk);
    chk("mr_grant", lsu_req_ready, 1);
    @(posedge clk); #1;
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = $urandom; lsu_resp_ready = 1'b0;
    @(negedge clk);
    chk("mr_busy", busy, 1);
    chk("mr_lsu_rvalid", lsu_resp_valid, 1);
    chk("mr_backpressure", mem_resp_ready, 0);
    #2;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
    rst = 1'b1;
    #1;
    check_quiet("mid_rst");
    clear_inputs();
    @(posedge clk); #2;
    rst = 1'b0;
    resp_q.delete();
    last_grant_m = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: pops expectations whenever the DUT completes a handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_req_unexpected: got addr %0h expected no request", mem_addr);
        end else begin
          mon_rq = req_q.pop_front();
          chk("mem_req_addr", mem_addr, mon_rq.addr);
          chk("mem_req_ctl", {mem_wen, mem_wdata, mem_wmask}, {mon_rq.wen, mon_rq.wdata, mon_rq.wmask});
        end
      end
      mon_ifu_hs = ifu_resp_valid && ifu_resp_ready;
      mon_lsu_hs = lsu_resp_valid && lsu_resp_ready;
      if (mon_ifu_hs || mon_lsu_hs) begin
        if (resp_q.size() == 0 || (mon_ifu_hs && mon_lsu_hs)) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: got ifu_hs=%0b lsu_hs=%0b expected one queued response",
                   mon_ifu_hs, mon_lsu_hs);
        end else begin
          mon_rs = resp_q.pop_front();
          chk("resp_port", mon_lsu_hs, mon_rs.owner);
          chk("resp_data", mon_lsu_hs ? lsu_rdata : ifu_rdata, mon_rs.data);
          chk("resp_err",  mon_lsu_hs ? lsu_resp_err : ifu_resp_err, mon_rs.err);
        end
      end
    end
  end

  initial begin
    int sel, d1, d2, rr;
    clear_inputs();
    ifu_addr = '0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    last_grant_m = 1'b0;
    rst = 1'b1;
    #1;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
    #2;
    check_quiet("reset");
    clear_inputs();
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;

    // Ties after reset: LSU, then IFU, then LSU
    run_txn(2, 32'h8000_0004, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h0, 1'b0);
    run_txn(2, 32'h8000_0004, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h1111_0000, 1'b0);
    run_txn(2, 32'h8000_0008, 32'h8000_1004, 1'b0, 32'h0, 4'h0, 1, 1, 0, 32'h2222_0000, 1'b0);
    // Single IFU fetch
    run_txn(0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 0, 32'h0000_0413, 1'b0);
    // LSU load with 3 cycles of owner backpressure
    run_txn(1, 32'h0, 32'h8000_2000, 1'b0, 32'h0, 4'h0, 0, 0, 4, 32'h1234_5678, 1'b0);
    // Slave never accepts: timeout to error
    run_txn(0, 32'h8000_0010, 32'h0, 1'b0, 32'h0, 4'h0, 100, 0, 0, 32'hAAAA_AAAA, 1'b0);
    // Slave accepts on the final watchdog cycle: still an error
    run_txn(0, 32'h8000_0014, 32'h0, 1'b0, 32'h0, 4'h0, T - 1, 0, 0, 32'hBBBB_BBBB, 1'b0);
    // Response on the final watchdog cycle wins
    run_txn(0, 32'h8000_0018, 32'h0, 1'b0, 32'h0, 4'h0, 0, T - 2, 0, 32'hCAFE_F00D, 1'b0);
    // Slave error passthrough
    run_txn(1, 32'h0, 32'h8000_3000, 1'b1, 32'h5555_AAAA, 4'h3, 1, 0, 0, 32'h0BAD_0BAD, 1'b1);
    // Async reset while in RESP, then tie must go to LSU
    mid_reset();
    run_txn(2, 32'h8000_0020, 32'h8000_4000, 1'b0, 32'h0, 4'h0, 0, 0, 0, 32'h3333_3333, 1'b0);

    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 2);
      d1  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 3);
      d2  = $urandom_range(0, 3);
      rr  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 11) : $urandom_range(0, 4);
      run_txn(sel, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
              4'($urandom_range(0, 15)), d1, d2, rr, $urandom,
              ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    chk("final_idle", busy, 0);
    chk("req_q_drained", req_q.size(), 0);
    chk("resp_q_drained", resp_q.size(), 0);
    summary();
    $finish;
  end

endmodule
